// File: rtl/count_event_monitor.sv
// rtl/count_event_monitor.sv - classifies count samples as HIT/WRAP/JUMP events
// and queues them, timestamped, in a small FIFO drained by valid/ready.
module count_event_monitor #(
  parameter int WIDTH  = 4,
  parameter int TARGET = 9,
  parameter int DEPTH  = 4,
  parameter int TS_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     count_valid,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [1:0]               evt_type,
  output logic [TS_W-1:0]          evt_time,
  output logic [$clog2(DEPTH):0]   evt_level,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  input  logic                     clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] TGT      = WIDTH'(TARGET);
  localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);

  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_HIT  = 2'b01;
  localparam logic [1:0] EV_WRAP = 2'b10;
  localparam logic [1:0] EV_JUMP = 2'b11;

  logic [TS_W-1:0]  ts;
  logic [WIDTH-1:0] prev;
  logic             prev_vld;
  logic [WIDTH-1:0] prev_inc;
  logic [1:0]       det_type;

  logic [1:0]       mem_type [DEPTH];
  logic [TS_W-1:0]  mem_time [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;

  logic evt_det, full, pop, push, drop;

  assign prev_inc = prev + WIDTH'(1);

  // JUMP outranks HIT outranks WRAP; a repeated value is a hold, not an event
  always_comb begin
    det_type = EV_NONE;
    if (count_valid) begin
      if (!prev_vld) begin
        if (count_in == TGT) det_type = EV_HIT;
      end else if (count_in == prev) begin
        det_type = EV_NONE;
      end else if (count_in == prev_inc) begin
        if (count_in == TGT)
          det_type = EV_HIT;
        else if (count_in == '0)
          det_type = EV_WRAP;
      end else begin
        det_type = EV_JUMP;
      end
    end
  end

  assign evt_det   = (det_type != EV_NONE);
  assign full      = (level == FULL_LVL);
  assign evt_valid = (level != '0);
  assign pop       = evt_valid && evt_ready;
  assign push      = evt_det && (!full || pop);
  assign drop      = evt_det && full && !pop;

  assign evt_type  = evt_valid ? mem_type[rd_ptr] : 2'b00;
  assign evt_time  = evt_valid ? mem_time[rd_ptr] : '0;
  assign evt_level = level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts       <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (count_valid) begin
        prev     <= count_in;
        prev_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_type[wr_ptr] <= det_type;
      mem_time[wr_ptr] <= ts;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // a drop in the same cycle as a clear restarts the tally at one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow)
        drop_count <= 8'd1;
      else if (drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end
  end

endmodule

// File: tb/tb_count_event_monitor.sv
// tb/tb_count_event_monitor.sv - randomized and directed checks of count_event_monitor
// against a queue-based behavioural model.
module tb_count_event_monitor;

  localparam int WIDTH  = 4;
  localparam int TARGET = 9;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] count_in = '0;
  logic             count_valid = 1'b0;
  logic             evt_valid;
  logic             evt_ready = 1'b0;
  logic [1:0]       evt_type;
  logic [TS_W-1:0]  evt_time;
  logic [2:0]       evt_level;
  logic             overflow;
  logic [7:0]       drop_count;
  logic             clear_overflow = 1'b0;

  count_event_monitor #(.WIDTH(WIDTH), .TARGET(TARGET), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_time(evt_time), .evt_level(evt_level), .overflow(overflow),
    .drop_count(drop_count), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int ty; int tm; } ev_t;

  int checks = 0;
  int passes = 0;
  bit started = 0;

  ev_t mq[$];
  ev_t acc[$];
  int  m_ts = 0, m_prev = 0, m_ovf = 0, m_dc = 0;
  bit  m_pv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: classify from the rules, FIFO as a plain queue
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ts = 0; m_prev = 0; m_pv = 0; m_ovf = 0; m_dc = 0;
    end else begin
      int ev, c;
      bit pop, full, drop;
      ev = 0;
      drop = 0;
      if (count_valid) begin
        c = int'(count_in);
        if (!m_pv) ev = (c == TARGET) ? 1 : 0;
        else if (c == m_prev) ev = 0;
        else if (c == (m_prev + 1) % (1 << WIDTH)) ev = (c == TARGET) ? 1 : (c == 0) ? 2 : 0;
        else ev = 3;
        m_prev = c;
        m_pv = 1;
      end
      full = (mq.size() == DEPTH);
      pop  = (mq.size() > 0) && evt_ready;
      if (pop) void'(mq.pop_front());
      if (ev != 0) begin
        if (!full || pop) mq.push_back('{ty: ev, tm: m_ts});
        else drop = 1;
      end
      if (drop) begin
        m_ovf = 1;
        m_dc = clear_overflow ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
      end else if (clear_overflow) begin
        m_ovf = 0;
        m_dc = 0;
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("evt_valid", evt_valid, mq.size() > 0);
      chk("evt_level", evt_level, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_count", drop_count, m_dc);
      if (mq.size() > 0) begin
        chk("evt_type", evt_type, mq[0].ty);
        chk("evt_time", evt_time, mq[0].tm);
      end
    end
  end

  always @(negedge clk) begin
    if (started && reset && evt_valid && evt_ready)
      acc.push_back('{ty: int'(evt_type), tm: int'(evt_time)});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sample(input int v);
    count_valid = 1'b1;
    count_in = WIDTH'(v);
    tick();
    count_valid = 1'b0;
  endtask

  task automatic do_reset();
    count_valid = 1'b0;
    evt_ready = 1'b0;
    clear_overflow = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    acc.delete();
  endtask

  initial begin
    int last;
    #1 reset = 1'b0;
    started = 1;
    chk("reset evt_valid", evt_valid, 0);
    chk("reset evt_level", evt_level, 0);
    chk("reset evt_type", evt_type, 0);
    chk("reset evt_time", evt_time, 0);
    chk("reset overflow", overflow, 0);
    chk("reset drop_count", drop_count, 0);
    tick();

    // full count sweep with wrap
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i <= 16; i++) sample(i % 16);
    tick(); tick();
    chk("sweep n_events", acc.size(), 2);
    if (acc.size() == 2) begin
      chk("sweep first type", acc[0].ty, 1);
      chk("sweep first time", acc[0].tm, 9);
      chk("sweep second type", acc[1].ty, 2);
      chk("sweep time delta", acc[1].tm - acc[0].tm, 7);
    end

    // hold across a valid gap, then a jump
    do_reset();
    evt_ready = 1'b1;
    sample(3); sample(4); tick(); sample(4); sample(7);
    tick(); tick();
    chk("jump n_events", acc.size(), 1);
    if (acc.size() == 1) chk("jump type", acc[0].ty, 3);

    // first-sample rules
    do_reset();
    evt_ready = 1'b1;
    sample(9);
    tick(); tick();
    chk("first9 n_events", acc.size(), 1);
    if (acc.size() == 1) begin
      chk("first9 type", acc[0].ty, 1);
      chk("first9 time", acc[0].tm, 0);
    end
    do_reset();
    evt_ready = 1'b1;
    sample(5); sample(9);
    tick(); tick();
    chk("first5 n_events", acc.size(), 1);
    if (acc.size() == 1) chk("first5 then 9 type", acc[0].ty, 3);

    // overflow with consumer stalled, then drain
    do_reset();
    for (int i = 0; i < 7; i++) sample((i % 2) * 5);
    tick();
    chk("ovf level", evt_level, 4);
    chk("ovf flag", overflow, 1);
    chk("ovf drop_count", drop_count, 2);
    chk("ovf head time", evt_time, 1);
    tick(); tick();
    chk("ovf head stable", evt_time, 1);
    chk("ovf head type", evt_type, 3);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drain n_events", acc.size(), 4);
    for (int i = 0; i < acc.size(); i++) chk("drain order", acc[i].tm, i + 1);
    chk("drain empty", evt_valid, 0);

    // full FIFO with simultaneous pop and push; clear vs drop
    do_reset();
    for (int i = 0; i < 5; i++) sample((i % 2) * 5);
    chk("full level", evt_level, 4);
    evt_ready = 1'b1;
    sample(5);
    evt_ready = 1'b0;
    chk("popush level", evt_level, 4);
    chk("popush no ovf", overflow, 0);
    sample(0); sample(5);
    chk("two drops", drop_count, 2);
    clear_overflow = 1'b1;
    sample(0);
    clear_overflow = 1'b0;
    chk("clear+drop ovf", overflow, 1);
    chk("clear+drop count", drop_count, 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clear ovf", overflow, 0);
    chk("clear count", drop_count, 0);

    // asynchronous reset mid-cycle with queued events
    do_reset();
    sample(0); sample(5); sample(0); sample(5);
    chk("pre-areset level", evt_level, 3);
    #1 reset = 1'b0;
    #1;
    chk("areset evt_valid", evt_valid, 0);
    chk("areset evt_level", evt_level, 0);
    chk("areset overflow", overflow, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    sample(9);
    chk("post-areset valid", evt_valid, 1);
    chk("post-areset time", evt_time, 0);
    chk("post-areset type", evt_type, 1);

    // randomized traffic
    do_reset();
    last = 0;
    for (int blk = 0; blk < 6; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 15 : (blk % 3 == 1) ? 60 : 95;
      for (int i = 0; i < 500; i++) begin
        int r;
        r = $urandom_range(0, 99);
        count_valid = ($urandom_range(0, 3) != 0);
        if (r < 55) last = (last + 1) % 16;
        else if (r >= 70) last = $urandom_range(0, 15);
        count_in = WIDTH'(last);
        evt_ready = ($urandom_range(0, 99) < rdy_pct);
        clear_overflow = ($urandom_range(0, 39) == 0);
        tick();
      end
    end
    count_valid = 1'b0;
    clear_overflow = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Receiving end of the counter's terminal-count notification. Watches a free-running counter value and classifies each new sample as a TARGET hit, a wrap-around, or a sequence break (jump).
- Timestamps every classified event and queues it in a small FIFO.
- The FIFO drains through a valid/ready handshake to a consumer, such as a scoreboard, interrupt logic or a logger.

Parameters:
- WIDTH, 4: width of the observed count.
- TARGET, 9: count value that raises a HIT event; range 0..2^WIDTH-1.
- DEPTH, 4: event FIFO entries; power of 2, at least 2.
- TS_W, 16: timestamp width.

Ports:
- clk  in  1: rising-edge clock.
- reset  in  1: asynchronous, active-low reset.
- count_in  in  WIDTH: observed count value.
- count_valid  in  1: count_in is sampled this cycle.
- evt_valid  out  1: FIFO head holds an event.
- evt_ready  in  1: consumer accepts the head.
- evt_type  out  2: head event type; 01=HIT, 10=WRAP, 11=JUMP.
- evt_time  out  TS_W: head event timestamp.
- evt_level  out  $clog2(DEPTH)+1: FIFO occupancy.
- overflow  out  1: sticky; at least one event was dropped.
- drop_count  out  8: number of dropped events, saturating.
- clear_overflow  in  1: synchronous clear of overflow and drop_count.

Behaviour:
- Reset (reset=0, asynchronous), all state cleared:
  - ts=0, prev=0, prev_vld=0.
  - FIFO empty, so evt_valid=0 and evt_level=0.
  - evt_type=0, evt_time=0, overflow=0, drop_count=0.
- Reset mid-operation discards all queued events. The first count_valid after release is treated as a first sample.
- Timestamp: ts increments by 1 every cycle out of reset and wraps modulo 2^TS_W. An event detected in cycle N carries that cycle's ts, i.e. the pre-increment value.
- Classification happens only when count_valid=1. With count_valid=0, nothing happens and prev is held.
  - First sample (prev_vld=0): no sequence check. Emits HIT if count_in==TARGET, otherwise nothing. Sets prev_vld=1.
  - count_in==prev: hold, no event.
  - count_in==(prev+1) mod 2^WIDTH:
    - HIT if count_in==TARGET;
    - else WRAP if count_in==0;
    - else nothing.
  - Any other value: JUMP. This includes an upstream counter reset to 0 from a non-max value.
  - Priority is JUMP > HIT > WRAP. With TARGET=0, a 15->0 step yields HIT only.
  - At most one event per cycle.
  - prev is updated to count_in on every valid sample.
- FIFO:
  - Push when an event is detected and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Pop when evt_valid && evt_ready.
  - evt_type and evt_time are driven from the head entry with no extra read latency. An event detected in cycle N is visible at the earliest in cycle N+1.
  - evt_type and evt_time must hold stable while evt_valid=1 and evt_ready=0.
  - Simultaneous push and pop on an empty FIFO is impossible, since evt_valid=0. On a non-empty FIFO the level is unchanged.
  - Pointers wrap modulo DEPTH.
- Overflow:
  - An event arriving when the FIFO is full with no pop is dropped.
  - overflow is set to 1 in the next cycle.
  - drop_count increments, saturating at 255.
  - Queued entries are never overwritten.
- clear_overflow=1 clears overflow and drop_count in the next cycle.
  - If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_count=1.
- evt_ready is ignored while evt_valid=0.

Test Plan:
- Reset, then feed 0,1,...,15,0 on consecutive cycles with evt_ready=1 -> exactly two events: HIT at the count=9 cycle, then WRAP at the count=0 cycle. Their evt_time values differ by 7.
- Sequence 3,4,4,7 with a count_valid gap between the 4s -> one JUMP (at 7); no event for the repeated 4.
- First sample after reset is 9 -> HIT. A first sample of 5 -> no event, and a following 9 -> JUMP (not HIT).
- evt_ready=0, generate 6 events with DEPTH=4 -> evt_level=4, overflow=1, drop_count=2.
  - Head is the first event, stable while not accepted.
  - Then raise evt_ready -> 4 events drain in order, one per cycle.
- FIFO full, with pop and new event in the same cycle -> no drop, evt_level stays 4. clear_overflow in the same cycle as a drop -> overflow=1, drop_count=1.
- Assert reset low asynchronously, mid-clock, with 3 queued events -> evt_valid=0, evt_level=0, overflow=0 immediately. After release, ts restarts from 0.
